// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern link: transmitter FSM encoding
// and the run-of-ones limit common to transmitter and detectors.
package seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_STUFF = 2'b10,
    ST_GAP   = 2'b11
  } tx_state_t;

  localparam int unsigned DEFAULT_RUN_MAX = 3;

endpackage

// File: rtl/serial_pattern_tx_stuff_ctrl.sv
// Ones-run tracker for the serial transmitter; requests a stuffed 0 once the
// bit currently on the line completes a run of RUN_MAX ones.
module stuff_ctrl import seq_pkg::*; #(
  parameter int unsigned RUN_MAX = DEFAULT_RUN_MAX
) (
  input  logic clk,
  input  logic reset,
  input  logic data_bit,
  input  logic valid,
  input  logic clear,
  input  logic enable,
  output logic stuff_req
);

  localparam int unsigned RW = $clog2(RUN_MAX + 1);

  // run counts the ones emitted before the bit currently on the line
  logic [RW-1:0] run;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run <= '0;
    end else if (clear) begin
      run <= '0;
    end else if (valid) begin
      if (!data_bit)
        run <= '0;
      else if (run != RW'(RUN_MAX))
        run <= run + RW'(1);
    end
  end

  assign stuff_req = enable && valid && data_bit && (run == RW'(RUN_MAX - 1));

endmodule

// File: rtl/serial_pattern_tx.sv
// MSB-first serial frame transmitter with optional zero-bit stuffing and a
// fixed idle gap after every frame.
module serial_pattern_tx import seq_pkg::*; #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned LW      = 5,
  parameter int unsigned RUN_MAX = DEFAULT_RUN_MAX,
  parameter int unsigned GAP     = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  input  logic [LW-1:0]    len_in,
  input  logic             stuff_en,
  output logic             ready,
  output logic             busy,
  output logic             w,
  output logic             w_valid,
  output logic             stuffed,
  output logic             done
);

  localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;

  tx_state_t        state, state_nxt;
  logic [WIDTH-1:0] sr, sr_nxt;
  logic [LW-1:0]    rem, rem_nxt;
  logic [GW-1:0]    gap_cnt, gap_nxt;
  logic             stuff_en_r, stuff_en_nxt;
  logic             w_nxt, w_valid_nxt, stuffed_nxt, done_nxt;
  logic             accept, stuff_req;
  logic [LW-1:0]    len_c;
  logic [WIDTH-1:0] sr_load;

  assign ready  = (state == ST_IDLE);
  assign busy   = ~ready;
  assign accept = start && ready;

  assign len_c   = (len_in > LW'(WIDTH)) ? LW'(WIDTH) : len_in;
  // Left-align the len-bit field so the next bit out is always sr[WIDTH-1]
  assign sr_load = data_in << (LW'(WIDTH) - len_c);

  stuff_ctrl #(.RUN_MAX(RUN_MAX)) u_stuff_ctrl (
    .clk       (clk),
    .reset     (reset),
    .data_bit  (w),
    .valid     (state == ST_SHIFT),
    .clear     (accept || (state == ST_STUFF)),
    .enable    (stuff_en_r),
    .stuff_req (stuff_req)
  );

  always_comb begin
    state_nxt    = state;
    sr_nxt       = sr;
    rem_nxt      = rem;
    gap_nxt      = gap_cnt;
    stuff_en_nxt = stuff_en_r;
    w_nxt        = 1'b0;
    w_valid_nxt  = 1'b0;
    stuffed_nxt  = 1'b0;
    done_nxt     = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          stuff_en_nxt = stuff_en;
          if (len_c != '0) begin
            state_nxt   = ST_SHIFT;
            w_nxt       = sr_load[WIDTH-1];
            w_valid_nxt = 1'b1;
            sr_nxt      = sr_load << 1;
            rem_nxt     = len_c - LW'(1);
          end else begin
            state_nxt = ST_GAP;
            done_nxt  = 1'b1;
            gap_nxt   = GW'(GAP - 1);
          end
        end
      end
      ST_SHIFT, ST_STUFF: begin
        if (state == ST_SHIFT && stuff_req) begin
          state_nxt   = ST_STUFF;
          w_valid_nxt = 1'b1;
          stuffed_nxt = 1'b1;
        end else if (rem != '0) begin
          state_nxt   = ST_SHIFT;
          w_nxt       = sr[WIDTH-1];
          w_valid_nxt = 1'b1;
          sr_nxt      = sr << 1;
          rem_nxt     = rem - LW'(1);
        end else begin
          state_nxt = ST_GAP;
          done_nxt  = 1'b1;
          gap_nxt   = GW'(GAP - 1);
        end
      end
      ST_GAP: begin
        if (gap_cnt == '0)
          state_nxt = ST_IDLE;
        else
          gap_nxt = gap_cnt - GW'(1);
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      sr         <= '0;
      rem        <= '0;
      gap_cnt    <= '0;
      stuff_en_r <= 1'b0;
      w          <= 1'b0;
      w_valid    <= 1'b0;
      stuffed    <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      sr         <= sr_nxt;
      rem        <= rem_nxt;
      gap_cnt    <= gap_nxt;
      stuff_en_r <= stuff_en_nxt;
      w          <= w_nxt;
      w_valid    <= w_valid_nxt;
      stuffed    <= stuffed_nxt;
      done       <= done_nxt;
    end
  end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Bench for serial_pattern_tx: directed frames plus random frames checked
// cycle by cycle against a bit-list model of the stuffed frame.
module tb_serial_pattern_tx;

  localparam int unsigned WIDTH   = 16;
  localparam int unsigned LW      = 5;
  localparam int unsigned RUN_MAX = 3;
  localparam int unsigned GAP     = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] data_in;
  logic [LW-1:0]    len_in;
  logic             stuff_en;
  logic             ready, busy, w, w_valid, stuffed, done;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic exp_w[$];
  logic exp_s[$];

  serial_pattern_tx #(
    .WIDTH   (WIDTH),
    .LW      (LW),
    .RUN_MAX (RUN_MAX),
    .GAP     (GAP)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .data_in  (data_in),
    .len_in   (len_in),
    .stuff_en (stuff_en),
    .ready    (ready),
    .busy     (busy),
    .w        (w),
    .w_valid  (w_valid),
    .stuffed  (stuffed),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Line contents of one frame: data bits MSB first, a 0 inserted after
  // every RUN_MAX consecutive ones when stuffing is on.
  function automatic void build(input logic [WIDTH-1:0] d, input int unsigned len, input logic en);
    int unsigned lc, run;
    exp_w.delete();
    exp_s.delete();
    lc  = (len > WIDTH) ? WIDTH : len;
    run = 0;
    for (int i = int'(lc) - 1; i >= 0; i--) begin
      exp_w.push_back(d[i]);
      exp_s.push_back(1'b0);
      run = d[i] ? run + 1 : 0;
      if (en && run == RUN_MAX) begin
        exp_w.push_back(1'b0);
        exp_s.push_back(1'b1);
        run = 0;
      end
    end
  endfunction

  // Called #1 after a clock edge with the DUT idle; returns #1 after the edge
  // on which ready is back.
  task automatic send_frame(input logic [WIDTH-1:0] d, input logic [LW-1:0] l,
                            input logic en, input logic noise);
    int unsigned n, last;
    check("ready_before_start", ready, 1);
    data_in  = d;
    len_in   = l;
    stuff_en = en;
    start    = 1'b1;
    build(d, l, en);
    n    = exp_w.size();
    last = n + 1 + GAP;
    @(posedge clk); #1;
    for (int unsigned k = 1; k <= last; k++) begin
      if (k <= n) begin
        check("w_valid_bit", w_valid, 1);
        check("w_bit", w, exp_w[k-1]);
        check("stuffed_bit", stuffed, exp_s[k-1]);
        check("done_mid", done, 0);
        check("busy_mid", busy, 1);
      end else if (k == n + 1) begin
        check("w_valid_end", w_valid, 0);
        check("w_end", w, 0);
        check("stuffed_end", stuffed, 0);
        check("done_pulse", done, 1);
        check("busy_end", busy, 1);
      end else if (k < last) begin
        check("w_valid_gap", w_valid, 0);
        check("done_gap", done, 0);
        check("ready_gap", ready, 0);
      end else begin
        check("ready_after", ready, 1);
        check("busy_after", busy, 0);
        check("done_after", done, 0);
        check("w_valid_after", w_valid, 0);
      end
      if (k < last) begin
        if (noise) begin
          start    = 1'($urandom_range(0, 1));
          data_in  = WIDTH'($urandom);
          len_in   = LW'($urandom);
          stuff_en = 1'($urandom_range(0, 1));
        end else begin
          start = 1'b0;
        end
        @(posedge clk); #1;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    data_in  = '0;
    len_in   = '0;
    stuff_en = 1'b0;
    #1;
    check("rst_w_valid", w_valid, 0);
    check("rst_w", w, 0);
    check("rst_stuffed", stuffed, 0);
    check("rst_done", done, 0);
    check("rst_ready", ready, 1);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    send_frame(16'h00B2, 5'd8, 1'b1, 1'b0);
    send_frame(16'h003F, 5'd6, 1'b1, 1'b0);
    send_frame(16'h003F, 5'd6, 1'b0, 1'b0);
    send_frame(16'h1234, 5'd0, 1'b1, 1'b0);
    send_frame(16'h8001, 5'd20, 1'b1, 1'b0);
    send_frame(16'hFFFF, 5'd16, 1'b1, 1'b1);

    // Abort during the third bit
    data_in  = 16'h00FF;
    len_in   = 5'd8;
    stuff_en = 1'b0;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check("abort_pre_valid", w_valid, 1);
    check("abort_pre_w", w, 1);
    reset = 1'b1;
    #1;
    check("abort_w_valid", w_valid, 0);
    check("abort_w", w, 0);
    check("abort_stuffed", stuffed, 0);
    check("abort_ready", ready, 1);
    @(posedge clk);
    @(negedge clk) reset = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      check("abort_no_done", done, 0);
      check("abort_idle_valid", w_valid, 0);
      check("abort_idle_ready", ready, 1);
    end

    for (int unsigned f = 0; f < 150; f++) begin
      logic [WIDTH-1:0] d;
      d = ($urandom_range(0, 3) == 0) ? '1 : WIDTH'($urandom);
      send_frame(d, LW'($urandom_range(0, 20)), 1'($urandom_range(0, 1)), 1'b1);
      if ($urandom_range(0, 2) == 0) begin
        @(posedge clk); #1;
        check("idle_hold_ready", ready, 1);
        check("idle_hold_valid", w_valid, 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_pattern_tx.md
Name: serial_pattern_tx

Overview:
- Serial bit-stream transmitter that drives the single-bit `w` line consumed by the team's Mealy sequence detectors.
- Loads a parallel word and a bit length, then shifts the word out MSB-first, one bit per clock.
- Optional bit stuffing inserts a 0 after RUN_MAX consecutive 1s, so the run-of-ones pattern cannot occur unless stuffing is disabled.
- Used as the stimulus/transmit end of the detector link, both on-board and in benches.

Parameters:
- WIDTH, 16, maximum frame length in bits (>=2).
- LW, 5, width of len_in; must hold WIDTH (clog2(WIDTH+1)).
- RUN_MAX, 3, consecutive 1s after which a 0 is stuffed (1..WIDTH).
- GAP, 2, idle cycles after each frame, with w=0 and w_valid=0 (>=1).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  frame request; accepted only when ready=1.
- data_in  in  WIDTH  frame payload; bits [len-1:0] are sent.
- len_in  in  LW  frame length in bits; values >WIDTH clamp to WIDTH.
- stuff_en  in  1  bit-stuffing enable, captured at start.
- ready  out  1  high in IDLE only (decoded from state).
- busy  out  1  inverse of ready.
- w  out  1  serial data bit, registered.
- w_valid  out  1  w carries a frame bit this cycle, registered.
- stuffed  out  1  current w is a stuffed 0, registered.
- done  out  1  one-cycle pulse at end of frame, registered.

Behaviour:
- Reset (asynchronous, active-high; clock clk):
  - state=IDLE.
  - w=0, w_valid=0, stuffed=0, done=0.
  - Shift register, bit counter, ones-run counter and gap counter all cleared.
- States: IDLE, SHIFT, STUFF, GAP.
- IDLE:
  - start=1 captures data_in, min(len_in,WIDTH) and stuff_en; ones-run is cleared.
  - If clamped len>0, go to SHIFT. The first bit, data_in[len-1], appears on w with w_valid=1 in the next cycle.
  - If len=0, go straight to GAP: no valid bits, done=1 in the next cycle.
- SHIFT:
  - Emits one data bit per cycle, MSB of the len-bit field first, down to bit 0.
  - ones-run increments on a 1 and clears on a 0.
  - If stuff_en=1 and ones-run reaches RUN_MAX on the bit just emitted, the next cycle is STUFF.
- STUFF:
  - Outputs w=0, w_valid=1, stuffed=1, and clears ones-run.
  - Returns to SHIFT if data bits remain; otherwise goes to GAP.
  - A trailing stuff after the final data bit is always sent.
- Frame end:
  - The cycle after the last valid bit (data or stuff), state=GAP, done=1 for exactly one cycle, w_valid=0, w=0.
  - GAP lasts GAP cycles, then the block returns to IDLE.
- Latency: frame occupies 1 + len + n_stuff + GAP cycles from start acceptance to ready.
- start while busy is ignored; it is not queued.
- Inputs are sampled only at acceptance; changes mid-frame have no effect.
- stuffed=1 implies w_valid=1 and w=0.
- Reset mid-frame aborts immediately: outputs go to reset values and no done is issued.

Decomposition:
- Shared package (seq_pkg) holds:
  - state encodings: IDLE=2'b00, SHIFT=2'b01, STUFF=2'b10, GAP=2'b11;
  - default RUN_MAX constant, shared with the detector side.
- One natural sub-module, stuff_ctrl: ones-run counter plus the stuff-request decision.
  - Inputs: bit, valid, clear, enable.
  - Output: stuff_req.
- The top level holds the FSM, shift register, length counter and gap counter.

Test Plan:
- start, len=8, data=8'b10110010, stuff_en=1 -> w=1,0,1,1,0,0,1,0 over 8 cycles with w_valid=1 and stuffed=0; done on cycle 9 after acceptance; ready 2 cycles later.
- len=6, data=6'b111111, stuff_en=1, RUN_MAX=3 -> w=1,1,1,0,1,1,1,0 (8 valid cycles), stuffed=1 on the 4th and 8th; done on the following cycle.
- Same frame with stuff_en=0 -> six consecutive 1s, stuffed never asserted, done after 6 bits.
- len=0 -> w_valid never asserted; done pulse the cycle after start; ready after GAP.
- len=20, data=16'h8001 -> clamps to 16 bits: 1, fourteen 0s, 1; no stuffing.
- Reset asserted during the 3rd bit -> w_valid/w/stuffed drop to 0 asynchronously, no done, ready=1 after release.
- start pulsed mid-frame -> ignored.
- Back-to-back start on the first ready cycle -> accepted; its first bit appears the next cycle.
